// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the drawers and VGA pins.
// master drives the timing, slave observes it.
interface vga_timing_gen_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       hs;
  logic       vs;
  logic       blank;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    output DrawX, DrawY, hs, vs, blank, frame_start, frame_count
  );

  modport slave (
    input DrawX, DrawY, hs, vs, blank, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing source on vga_clk.
// Optional feature: define VGA_SYNC_DELAY_EN to delay hs/vs/blank by SYNC_DELAY clocks.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  vga_timing_gen_if.master  vga_o
);

  localparam int unsigned HTotal = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HsLo   = H_VISIBLE + H_FP;
  localparam int unsigned HsHi   = HsLo + H_SYNC;
  localparam int unsigned VsLo   = V_VISIBLE + V_FP;
  localparam int unsigned VsHi   = VsLo + V_SYNC;
  localparam logic [9:0]  HMax   = 10'(HTotal - 1);
  localparam logic [9:0]  VMax   = 10'(VTotal - 1);

  if (HTotal > 1024 || VTotal > 1024 || HTotal == 0 || VTotal == 0) begin : g_bad_totals
    $error("vga_timing_gen: H/V totals must be 1..1024");
  end
  if (SYNC_DELAY < 1 || SYNC_DELAY > 7) begin : g_bad_delay
    $error("vga_timing_gen: SYNC_DELAY must be 1..7");
  end

  logic [9:0] x_q, x_d, y_q, y_d;
  logic [7:0] fc_q, fc_d;
  logic       started_q;
  logic       hs_q, hs_d, vs_q, vs_d, blank_q, blank_d, fs_q, fs_d;
  logic       wrap;

  always_comb begin
    wrap    = (x_q == HMax) && (y_q == VMax);
    x_d     = (x_q == HMax) ? 10'd0 : x_q + 10'd1;
    y_d     = y_q;
    if (x_q == HMax) begin
      y_d = (y_q == VMax) ? 10'd0 : y_q + 10'd1;
    end
    // The wrap out of the reset state is not a completed frame.
    fc_d    = (wrap && started_q) ? fc_q + 8'd1 : fc_q;
    // Decoded from next-state counters so they align with DrawX/DrawY of the same cycle.
    hs_d    = !((32'(x_d) >= HsLo) && (32'(x_d) < HsHi));
    vs_d    = !((32'(y_d) >= VsLo) && (32'(y_d) < VsHi));
    blank_d = (32'(x_d) < H_VISIBLE) && (32'(y_d) < V_VISIBLE);
    fs_d    = (x_d == 10'd0) && (y_d == 10'd0);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q       <= HMax;
      y_q       <= VMax;
      fc_q      <= 8'd0;
      started_q <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_q   <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      fc_q      <= fc_d;
      started_q <= 1'b1;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_q   <= blank_d;
      fs_q      <= fs_d;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic [SYNC_DELAY-1:0] hs_pipe_q, vs_pipe_q, blank_pipe_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_pipe_q    <= '1;
      vs_pipe_q    <= '1;
      blank_pipe_q <= '0;
    end else begin
      hs_pipe_q[0]    <= hs_q;
      vs_pipe_q[0]    <= vs_q;
      blank_pipe_q[0] <= blank_q;
      for (int i = 1; i < int'(SYNC_DELAY); i++) begin
        hs_pipe_q[i]    <= hs_pipe_q[i-1];
        vs_pipe_q[i]    <= vs_pipe_q[i-1];
        blank_pipe_q[i] <= blank_pipe_q[i-1];
      end
    end
  end

  assign vga_o.hs    = hs_pipe_q[SYNC_DELAY-1];
  assign vga_o.vs    = vs_pipe_q[SYNC_DELAY-1];
  assign vga_o.blank = blank_pipe_q[SYNC_DELAY-1];
`else
  assign vga_o.hs    = hs_q;
  assign vga_o.vs    = vs_q;
  assign vga_o.blank = blank_q;
`endif

  assign vga_o.DrawX       = x_q;
  assign vga_o.DrawY       = y_q;
  assign vga_o.frame_start = fs_q;
  assign vga_o.frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a full 640x480 instance for line-level timing and a tiny-raster instance
// for frame-level behaviour (vs window, frame_count wrap) within a short run.
module tb_vga_timing_gen;

  localparam int unsigned SD = 2;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       fs;
    logic [7:0] fc;
  } exp_t;

  localparam exp_t RstA = '{x: 10'd799, y: 10'd524, hs: 1'b1, vs: 1'b1, blank: 1'b0,
                            fs: 1'b0, fc: 8'd0};
  localparam exp_t RstB = '{x: 10'd14, y: 10'd10, hs: 1'b1, vs: 1'b1, blank: 1'b0,
                            fs: 1'b0, fc: 8'd0};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen_if ifa ();
  vga_timing_gen_if ifb ();

  vga_timing_gen #(.SYNC_DELAY(SD)) dut_a (
    .vga_clk (clk),
    .reset_n (reset_n),
    .vga_o   (ifa)
  );

  vga_timing_gen #(
    .H_VISIBLE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_VISIBLE (6), .V_FP (1), .V_SYNC (2), .V_BP (2),
    .SYNC_DELAY(SD)
  ) dut_b (
    .vga_clk (clk),
    .reset_n (reset_n),
    .vga_o   (ifb)
  );

  int checks = 0;
  int errors = 0;

  // Reference: position is simply elapsed clocks since reset release, folded by the raster size.
  function automatic exp_t model(int unsigned t, int unsigned hv, int unsigned hf,
                                 int unsigned hsy, int unsigned hb, int unsigned vv,
                                 int unsigned vf, int unsigned vsy, int unsigned vb);
    exp_t e;
    int unsigned ht = hv + hf + hsy + hb;
    int unsigned vt = vv + vf + vsy + vb;
    int unsigned x  = t % ht;
    int unsigned y  = (t / ht) % vt;
    e.x     = 10'(x);
    e.y     = 10'(y);
    e.hs    = !(x >= hv + hf && x < hv + hf + hsy);
    e.vs    = !(y >= vv + vf && y < vv + vf + vsy);
    e.blank = (x < hv) && (y < vv);
    e.fs    = (x == 0) && (y == 0);
    e.fc    = 8'((t / (ht * vt)) % 256);
    return e;
  endfunction

  task automatic cmp(input string nm, input exp_t exp, input exp_t act);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t got x=%0d y=%0d hs=%b vs=%b blank=%b fs=%b fc=%0d exp x=%0d y=%0d hs=%b vs=%b blank=%b fs=%b fc=%0d",
               nm, $time, act.x, act.y, act.hs, act.vs, act.blank, act.fs, act.fc,
               exp.x, exp.y, exp.hs, exp.vs, exp.blank, exp.fs, exp.fc);
    end
  endtask

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int unsigned ta = 0, tb = 0;
`ifdef VGA_SYNC_DELAY_EN
  logic [2:0] hist_a[$];
  logic [2:0] hist_b[$];
`endif

  // Model side: one expected entry per rising edge.
  always @(posedge clk) begin
    if (!reset_n) begin
      ta = 0;
      tb = 0;
      ea = RstA;
      eb = RstB;
`ifdef VGA_SYNC_DELAY_EN
      hist_a.delete();
      hist_b.delete();
      repeat (SD) begin
        hist_a.push_back(3'b110);
        hist_b.push_back(3'b110);
      end
`endif
    end else begin
      ea = model(ta, 640, 16, 96, 48, 480, 10, 2, 33);
      eb = model(tb, 8, 2, 3, 2, 6, 1, 2, 2);
      ta++;
      tb++;
`ifdef VGA_SYNC_DELAY_EN
      hist_a.push_back({ea.hs, ea.vs, ea.blank});
      hist_b.push_back({eb.hs, eb.vs, eb.blank});
      {ea.hs, ea.vs, ea.blank} = hist_a.pop_front();
      {eb.hs, eb.vs, eb.blank} = hist_b.pop_front();
`endif
    end
    qa.push_back(ea);
    qb.push_back(eb);
  end

  exp_t act_a, act_b;
  logic [7:0] prev_fc_b = 8'd0;
  bit wrap_seen = 1'b0;

  // Monitor side: the DUT presents a new raster position every clock; sample on the falling edge.
  always @(negedge clk) begin
    act_a = {ifa.DrawX, ifa.DrawY, ifa.hs, ifa.vs, ifa.blank, ifa.frame_start, ifa.frame_count};
    act_b = {ifb.DrawX, ifb.DrawY, ifb.hs, ifb.vs, ifb.blank, ifb.frame_start, ifb.frame_count};
    if (qa.size() > 0) cmp("dut_a", qa.pop_front(), act_a);
    if (qb.size() > 0) cmp("dut_b", qb.pop_front(), act_b);
    if (prev_fc_b == 8'd255 && ifb.frame_count == 8'd0) wrap_seen = 1'b1;
    prev_fc_b = ifb.frame_count;
  end

  task automatic check_reset_now();
    exp_t a, b;
    a = {ifa.DrawX, ifa.DrawY, ifa.hs, ifa.vs, ifa.blank, ifa.frame_start, ifa.frame_count};
    b = {ifb.DrawX, ifb.DrawY, ifb.hs, ifb.vs, ifb.blank, ifb.frame_start, ifb.frame_count};
    cmp("reset_a", RstA, a);
    cmp("reset_b", RstB, b);
  endtask

  initial begin
    bit found;
    reset_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1 check_reset_now();
    reset_n = 1'b1;

    // Past the DrawY=5 -> 6 line wrap on the full raster, plus a random tail.
    repeat (5000 + $urandom_range(0, 400)) @(negedge clk);

    // Mid-line asynchronous reset at DrawX=300.
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (ifa.DrawX == 10'd300) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_reset_wait got DrawX never 300 exp DrawX==300 within 1000 clocks");
    end
    #1 reset_n = 1'b0;
    #1 check_reset_now();
    repeat ($urandom_range(1, 4)) @(negedge clk);
    #1 reset_n = 1'b1;

    // 257 tiny frames (165 clocks each) to reach the frame_count wrap.
    repeat (257 * 165 + 300) @(negedge clk);
    checks++;
    if (!wrap_seen) begin
      errors++;
      $display("FAIL fc_wrap got no 255->0 transition exp 255->0 observed");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
